// File: rtl/xadc_drp_if.sv
// rtl/xadc_drp_if.sv - XADC DRP port and conversion-status signals
// The sequencer uses the master modport; the XADC (or a model of it) uses the slave modport.
interface xadc_drp_if;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        den_out;
  logic        dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;

  modport master (
    input  eoc_in, channel_in, drdy_in, do_in,
    output den_out, dwe_out, daddr_out, di_out
  );

  modport slave (
    output eoc_in, channel_in, drdy_in, do_in,
    input  den_out, dwe_out, daddr_out, di_out
  );
endinterface

// File: rtl/xadc_drp_reader.sv
// rtl/xadc_drp_reader.sv - XADC DRP read sequencer with raw sample and boxcar average
// Each qualified end-of-conversion issues one DRP read; results are averaged over 2^AVG_LOG2 samples.
module xadc_drp_reader #(
  parameter logic [4:0] CHANNEL  = 5'd6,
  parameter logic [6:0] DRP_ADDR = 7'h16,
  parameter int         AVG_LOG2 = 4,
  parameter int         TIMEOUT  = 64
) (
  input  logic         dclk_in,
  input  logic         reset_n_in,
  input  logic         en_in,
  xadc_drp_if.master   drp,
  output logic [11:0]  raw_out,
  output logic         raw_valid_out,
  output logic [11:0]  avg_out,
  output logic         avg_valid_out,
  output logic         timeout_out,
  output logic         overrun_out
);
  localparam int ACC_W   = 12 + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int TIMER_W = 10;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        raw_q, raw_d, avg_q, avg_d;
  logic               raw_valid_q, raw_valid_d, avg_valid_q, avg_valid_d;
  logic               timeout_q, timeout_d, overrun_q, overrun_d;
  logic               den_q, den_d, drop_q, drop_d;
  logic [6:0]         daddr_q, daddr_d;

  logic               qual;
  logic [11:0]        sample;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   avg_shift;

  assign qual      = drp.eoc_in && (drp.channel_in == CHANNEL);
  assign sample    = drp.do_in[15:4];
  assign sum       = acc_q + ACC_W'(sample);
  assign avg_shift = sum >> AVG_LOG2;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    raw_d       = raw_q;
    avg_d       = avg_q;
    raw_valid_d = 1'b0;
    avg_valid_d = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = overrun_q;
    den_d       = 1'b0;
    daddr_d     = 7'd0;
    drop_d      = drop_q;

    case (state_q)
      IDLE: begin
        drop_d  = 1'b0;
        timer_d = '0;
        if (en_in && qual) begin
          state_d = REQ;
          den_d   = 1'b1;
          daddr_d = DRP_ADDR;
        end
      end
      REQ: begin
        timer_d = timer_q + TIMER_W'(1);
        state_d = WAIT;
        if (!en_in) drop_d = 1'b1;
      end
      WAIT: begin
        if (!en_in) drop_d = 1'b1;
        // drdy takes priority over an expiring timer on the same edge
        if (drp.drdy_in) begin
          state_d = IDLE;
          if (en_in && !drop_q) begin
            raw_d       = sample;
            raw_valid_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
              avg_d       = avg_shift[11:0];
              avg_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling wipes the partial average and the overrun flag every cycle it is held
    if (!en_in) begin
      acc_d     = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (qual && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge dclk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      raw_q       <= '0;
      avg_q       <= '0;
      raw_valid_q <= 1'b0;
      avg_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      den_q       <= 1'b0;
      daddr_q     <= 7'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      raw_q       <= raw_d;
      avg_q       <= avg_d;
      raw_valid_q <= raw_valid_d;
      avg_valid_q <= avg_valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      den_q       <= den_d;
      daddr_q     <= daddr_d;
      drop_q      <= drop_d;
    end
  end

  assign drp.den_out   = den_q;
  assign drp.daddr_out = daddr_q;
  assign drp.dwe_out   = 1'b0;
  assign drp.di_out    = 16'h0000;
  assign raw_out       = raw_q;
  assign raw_valid_out = raw_valid_q;
  assign avg_out       = avg_q;
  assign avg_valid_out = avg_valid_q;
  assign timeout_out   = timeout_q;
  assign overrun_out   = overrun_q;
endmodule

// File: tb/tb_xadc_drp_reader.sv
// tb/tb_xadc_drp_reader.sv - scoreboard bench for xadc_drp_reader
// Stimulus pushes expected samples/averages; a negedge monitor pops and compares.
module tb_xadc_drp_reader;
  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [11:0] raw, avg;
  logic raw_v, avg_v, tmo, ovr;

  always #5 clk = ~clk;

  xadc_drp_if drp();

  xadc_drp_reader dut (
    .dclk_in       (clk),
    .reset_n_in    (rst_n),
    .en_in         (en),
    .drp           (drp),
    .raw_out       (raw),
    .raw_valid_out (raw_v),
    .avg_out       (avg),
    .avg_valid_out (avg_v),
    .timeout_out   (tmo),
    .overrun_out   (ovr)
  );

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_raw_q[$];
  logic [11:0] exp_avg_q[$];
  int model_q[$];
  int exp_dens = 0, seen_dens = 0, exp_tmo = 0, seen_tmo = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: a plain list of accepted samples; every 16th completes an integer-mean average
  task automatic model_capture(input logic [15:0] d);
    int sum;
    exp_raw_q.push_back(d[15:4]);
    model_q.push_back(int'(d[15:4]));
    if (model_q.size() == 16) begin
      sum = 0;
      foreach (model_q[i]) sum += model_q[i];
      exp_avg_q.push_back(12'(sum / 16));
      model_q.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic en_pulse();
    en = 1'b0;
    model_q.delete();
    step();
    en = 1'b1;
  endtask

  // Leaves the caller in the cycle where den_out should be high
  task automatic start_read();
    drp.eoc_in = 1'b1;
    drp.channel_in = 5'd6;
    step();
    drp.eoc_in = 1'b0;
    drp.channel_in = 5'($urandom_range(0, 31));
    check("den_latency", drp.den_out, 1);
    exp_dens++;
  endtask

  task automatic finish_read(input logic [15:0] d, input int delay, input bit capture);
    repeat (delay) step();
    drp.drdy_in = 1'b1;
    drp.do_in = d;
    if (capture) model_capture(d);
    step();
    drp.drdy_in = 1'b0;
    drp.do_in = 16'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (drp.den_out) begin
        seen_dens++;
        check("den_daddr", drp.daddr_out, 7'h16);
        check("den_dwe", drp.dwe_out, 0);
      end
      if (tmo) seen_tmo++;
      if (raw_v) begin
        if (exp_raw_q.size() == 0) check("raw_unexpected", 1, 0);
        else check("raw_value", raw, exp_raw_q.pop_front());
      end
      if (avg_v) begin
        check("avg_with_raw", raw_v, 1);
        if (exp_avg_q.size() == 0) check("avg_unexpected", 1, 0);
        else check("avg_value", avg, exp_avg_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    logic [15:0] d;
    rst_n = 1'b0;
    en = 1'b0;
    drp.eoc_in = 1'b0;
    drp.channel_in = 5'd0;
    drp.drdy_in = 1'b0;
    drp.do_in = 16'h0;
    repeat (3) step();
    check("rst_den", drp.den_out, 0);
    check("rst_raw", {raw_v, raw}, 0);
    check("rst_avg", {avg_v, avg}, 0);
    check("rst_flags", {tmo, ovr, drp.daddr_out}, 0);
    rst_n = 1'b1;
    step();
    en = 1'b1;
    step();

    // Basic read, drdy 3 cycles after den
    start_read();
    finish_read(16'hABC0, 3, 1'b1);
    step();
    check("raw_hold", raw, 12'hABC);

    // Ramp 0..15 gives average 120>>4 = 7
    en_pulse();
    for (int i = 0; i < 16; i++) begin
      start_read();
      finish_read(16'(i << 4), $urandom_range(1, 10), 1'b1);
    end
    step();
    check("avg_ramp_hold", avg, 12'd7);

    // Other channel never starts a read
    drp.eoc_in = 1'b1;
    drp.channel_in = 5'd5;
    step();
    drp.eoc_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ch5_no_den", drp.den_out, 0);
      step();
    end

    // Qualified eoc while busy: not queued, sets sticky overrun
    start_read();
    step();
    drp.eoc_in = 1'b1;
    drp.channel_in = 5'd6;
    step();
    drp.eoc_in = 1'b0;
    check("overrun_no_den", drp.den_out, 0);
    check("overrun_set", ovr, 1);
    finish_read(16'h1230, 1, 1'b1);
    repeat (3) step();
    check("overrun_sticky", ovr, 1);
    en_pulse();
    check("overrun_cleared", ovr, 0);
    step();

    // No drdy: timeout pulse 64 cycles after den
    start_read();
    n = 0;
    while (n < 200 && !tmo) begin
      step();
      n++;
    end
    check("timeout_latency", n, 64);
    exp_tmo++;
    step();
    start_read();
    finish_read(16'h5550, 2, 1'b1);
    step();

    // All-ones samples
    en_pulse();
    for (int i = 0; i < 16; i++) begin
      start_read();
      finish_read(16'hFFF0, $urandom_range(1, 5), 1'b1);
    end
    step();
    check("avg_ones_hold", avg, 12'hFFF);

    // Randomised reads with noise: stray drdy, other-channel eoc, occasional disable mid-read
    en_pulse();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        drp.drdy_in = 1'($urandom_range(0, 1));
        drp.eoc_in = 1'($urandom_range(0, 1));
        drp.channel_in = 5'($urandom_range(7, 31));
        step();
      end
      drp.drdy_in = 1'b0;
      drp.eoc_in = 1'b0;
      d = 16'($urandom);
      start_read();
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0;
        model_q.delete();
        finish_read(d, $urandom_range(1, 30), 1'b0);
        en = 1'b1;
      end else begin
        finish_read(d, $urandom_range(1, 30), 1'b1);
      end
    end
    step();

    // Async reset in WAIT clears everything at once; later drdy is ignored
    start_read();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_raw", {raw_v, raw}, 0);
    check("arst_avg", {avg_v, avg}, 0);
    check("arst_den", drp.den_out, 0);
    check("arst_flags", {tmo, ovr}, 0);
    model_q.delete();
    step();
    rst_n = 1'b1;
    step();
    drp.drdy_in = 1'b1;
    drp.do_in = 16'h7770;
    step();
    drp.drdy_in = 1'b0;
    repeat (3) step();

    check("den_count", seen_dens, exp_dens);
    check("timeout_count", seen_tmo, exp_tmo);
    check("raw_queue_empty", exp_raw_q.size(), 0);
    check("avg_queue_empty", exp_avg_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
